// File: rtl/scr1_tb_axi_throttle.sv
// ----------------------------------------------------------------------------
// scr1_tb_axi_throttle
//
// Handshake throttle placed between the core AXI bridge and the AXI TB
// memory. It inserts fixed or pseudo-random per-beat delays on the valid and
// ready lines of the five AXI channels. Payload signals bypass this block.
//
// Channel index: 0=AW 1=W 2=B 3=AR 4=R. "src" is the producer of a channel
// and "dst" is the consumer. For B and R, src is the memory side.
//
// Handshake semantics on every channel: a beat transfers in the cycle where
// valid and ready are both high. A producer that raises valid must hold it
// until that cycle. Dropping it earlier is recorded in proto_err.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   cfg_mode     0 = bypass, 1 = fixed delay, 2 = random delay, 3 = bypass
//   cfg_dly      fixed delay, or upper bound for the random delay
//   cfg_ch_en    per-channel throttle enable (0 = channel bypassed)
//   src_valid    producer valid           src_ready  ready back to producer
//   dst_valid    valid toward consumer    dst_ready  consumer ready
//   proto_err    sticky flag: src_valid dropped before its handshake
//   stall_cnt    cycles with src_valid & !src_ready  (STAT_EN builds only)
//   xfer_cnt     completed handshakes                (STAT_EN builds only)
//
// Build option: define SCR1_TB_AXI_THROTTLE_STAT_EN to add the saturating
// per-channel stall_cnt and xfer_cnt statistics counters.
// ----------------------------------------------------------------------------
module scr1_tb_axi_throttle #(
    parameter int          W_DLY = 4,
    parameter logic [15:0] SEED  = 16'hACE1
`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
    ,
    parameter int          W_CNT = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_mode,
    input  logic [W_DLY-1:0] cfg_dly,
    input  logic [4:0]       cfg_ch_en,
    input  logic [4:0]       src_valid,
    output logic [4:0]       src_ready,
    output logic [4:0]       dst_valid,
    input  logic [4:0]       dst_ready,
    output logic [4:0]       proto_err
`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
    ,
    output logic [4:0][W_CNT-1:0] stall_cnt,
    output logic [4:0][W_CNT-1:0] xfer_cnt
`endif
);

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DLY  = 2'd1,
        ST_OPEN = 2'd2
    } state_e;

    state_e           state_q [5];
    state_e           state_d [5];
    logic [W_DLY-1:0] cnt_q   [5];
    logic [W_DLY-1:0] cnt_d   [5];
    logic [15:0]      lfsr_q  [5];
    logic [4:0]       err_q;
    logic [4:0]       err_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

    // cnt holds the number of quiet DLY cycles still to run, including the
    // current one. A beat with delay d spends its first cycle in IDLE, so it
    // enters DLY with d-1 and leaves for OPEN when cnt reaches 1. A delay of
    // 1 goes straight to OPEN. The net effect is that dst_valid rises exactly
    // d cycles after src_valid first appears.
    always_comb begin
        logic             byp;
        logic [W_DLY-1:0] d;
        for (int c = 0; c < 5; c++) begin
            state_d[c]   = state_q[c];
            cnt_d[c]     = cnt_q[c];
            err_d[c]     = err_q[c];
            dst_valid[c] = 1'b0;
            src_ready[c] = 1'b0;
            byp = (cfg_mode == 2'd0) || (cfg_mode == 2'd3) || !cfg_ch_en[c];
            if (cfg_mode == 2'd2 && lfsr_q[c][W_DLY-1:0] < cfg_dly) begin
                d = lfsr_q[c][W_DLY-1:0];
            end else begin
                d = cfg_dly;
            end

            if (byp) begin
                dst_valid[c] = src_valid[c];
                src_ready[c] = dst_ready[c];
                state_d[c]   = ST_IDLE;
            end else begin
                case (state_q[c])
                    ST_IDLE: begin
                        if (src_valid[c]) begin
                            if (d == '0) begin
                                dst_valid[c] = 1'b1;
                                src_ready[c] = dst_ready[c];
                                if (!dst_ready[c]) state_d[c] = ST_OPEN;
                            end else if (d == W_DLY'(1)) begin
                                state_d[c] = ST_OPEN;
                            end else begin
                                state_d[c] = ST_DLY;
                                cnt_d[c]   = d - W_DLY'(1);
                            end
                        end
                    end
                    ST_DLY: begin
                        if (!src_valid[c]) begin
                            err_d[c]   = 1'b1;
                            state_d[c] = ST_IDLE;
                        end else if (cnt_q[c] == W_DLY'(1)) begin
                            state_d[c] = ST_OPEN;
                        end else begin
                            cnt_d[c] = cnt_q[c] - W_DLY'(1);
                        end
                    end
                    ST_OPEN: begin
                        dst_valid[c] = src_valid[c];
                        src_ready[c] = dst_ready[c];
                        if (!src_valid[c]) begin
                            err_d[c]   = 1'b1;
                            state_d[c] = ST_IDLE;
                        end else if (dst_ready[c]) begin
                            state_d[c] = ST_IDLE;
                        end
                    end
                    default: begin
                        state_d[c] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // The LFSRs run freely every cycle so that the random delay sequence
    // does not depend on traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 5; c++) begin
                state_q[c] <= ST_IDLE;
                cnt_q[c]   <= '0;
                lfsr_q[c]  <= SEED ^ 16'(c + 1);
            end
            err_q <= '0;
        end else begin
            for (int c = 0; c < 5; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                lfsr_q[c]  <= lfsr_step(lfsr_q[c]);
            end
            err_q <= err_d;
        end
    end

    assign proto_err = err_q;

`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
    logic [4:0][W_CNT-1:0] stall_q;
    logic [4:0][W_CNT-1:0] xfer_q;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            xfer_q  <= '0;
        end else begin
            for (int c = 0; c < 5; c++) begin
                if (src_valid[c] && !src_ready[c] && (stall_q[c] != '1)) begin
                    stall_q[c] <= stall_q[c] + W_CNT'(1);
                end
                if (src_valid[c] && src_ready[c] && (xfer_q[c] != '1)) begin
                    xfer_q[c] <= xfer_q[c] + W_CNT'(1);
                end
            end
        end
    end

    assign stall_cnt = stall_q;
    assign xfer_cnt  = xfer_q;
`endif

endmodule

// File: tb/tb_scr1_tb_axi_throttle.sv
// Bench for scr1_tb_axi_throttle. The reference model tracks each channel
// by beat: it knows when the beat started, its delay, and its age in cycles.
// From those it derives the expected valid and ready values per cycle.
module tb_scr1_tb_axi_throttle;
  localparam logic [15:0] SEED = 16'hACE1;
`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
  localparam int W_CNT = 8;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_dly;
  logic [4:0] cfg_ch_en;
  logic [4:0] src_valid;
  logic [4:0] src_ready;
  logic [4:0] dst_valid;
  logic [4:0] dst_ready;
  logic [4:0] proto_err;
`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
  logic [4:0][W_CNT-1:0] stall_cnt;
  logic [4:0][W_CNT-1:0] xfer_cnt;
`endif

  always #5 clk = ~clk;

  scr1_tb_axi_throttle #(
    .W_DLY (4),
    .SEED  (SEED)
`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
    ,
    .W_CNT (W_CNT)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_mode  (cfg_mode),
    .cfg_dly   (cfg_dly),
    .cfg_ch_en (cfg_ch_en),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .dst_valid (dst_valid),
    .dst_ready (dst_ready),
    .proto_err (proto_err)
`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .xfer_cnt  (xfer_cnt)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit   [4:0]  m_act;
  int          m_age  [5];
  int          m_d    [5];
  logic [4:0]  m_err;
  logic [15:0] m_lfsr [5];
`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
  logic [W_CNT-1:0] m_stall [5];
  logic [W_CNT-1:0] m_xfer  [5];
  logic [W_CNT-1:0] e_stall [5];
  logic [W_CNT-1:0] e_xfer  [5];
`endif
  logic [14:0] exp_q[$];   // {proto_err, src_ready, dst_valid}

  int  cur_age3;
  bit  cur_act3;
  bit  lat_seen;
  bit  hist_on;
  int  lat_hist [16];
  int  beats3;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int pick_delay(input int c);
    int r;
    if (cfg_mode == 2'd1) return int'(cfg_dly);
    r = int'(m_lfsr[c][3:0]);
    return (r < int'(cfg_dly)) ? r : int'(cfg_dly);
  endfunction

  task automatic model_eval();
    logic [4:0] e_dv;
    logic [4:0] e_sr;
    logic [4:0] e_err;
    bit byp;
    bit open;
    e_dv     = '0;
    e_sr     = '0;
    e_err    = rst_n ? m_err : 5'd0;
    cur_act3 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      byp = (cfg_mode == 2'd0) || (cfg_mode == 2'd3) || !cfg_ch_en[c];
      if (!rst_n) begin
        m_act[c]  = 1'b0;
        m_err[c]  = 1'b0;
        m_lfsr[c] = SEED ^ 16'(c + 1);
        if (byp || (src_valid[c] && pick_delay(c) == 0)) begin
          e_dv[c] = src_valid[c];
          e_sr[c] = dst_ready[c];
        end
      end else if (byp) begin
        e_dv[c]  = src_valid[c];
        e_sr[c]  = dst_ready[c];
        m_act[c] = 1'b0;
      end else begin
        if (!m_act[c] && src_valid[c]) begin
          m_act[c] = 1'b1;
          m_age[c] = 0;
          m_d[c]   = pick_delay(c);
          if (c == 3) lat_seen = 1'b0;
        end
        if (m_act[c]) begin
          open = (m_age[c] >= m_d[c]);
          e_dv[c] = open && src_valid[c];
          e_sr[c] = open && dst_ready[c];
          if (c == 3) begin
            cur_act3 = 1'b1;
            cur_age3 = m_age[c];
          end
          if (!src_valid[c]) begin
            m_err[c] = 1'b1;
            m_act[c] = 1'b0;
          end else if (open && dst_ready[c]) begin
            m_act[c] = 1'b0;
          end else begin
            m_age[c]++;
          end
        end
      end
`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
      if (!rst_n) begin
        m_stall[c] = '0;
        m_xfer[c]  = '0;
      end
      e_stall[c] = m_stall[c];
      e_xfer[c]  = m_xfer[c];
      if (rst_n) begin
        if (src_valid[c] && !e_sr[c] && m_stall[c] != '1) m_stall[c] = m_stall[c] + 1'b1;
        if (src_valid[c] && e_sr[c] && m_xfer[c] != '1) m_xfer[c] = m_xfer[c] + 1'b1;
      end
`endif
      if (rst_n) m_lfsr[c] = lfsr_next(m_lfsr[c]);
    end
    exp_q.push_back({e_err, e_sr, e_dv});
  endtask

  // ---------------- driver ----------------
  logic [4:0] last_sr;
  logic [4:0] obs_dv;
  logic [4:0] obs_sr;
  logic [4:0] obs_err;
  bit         new_beats = 1'b1;

  task automatic run_cycle();
    logic [14:0] e;
    @(negedge clk);
    obs_dv  = dst_valid;
    obs_sr  = src_ready;
    obs_err = proto_err;
    model_eval();
    e = exp_q.pop_front();
    check_eq("dst_valid", obs_dv, e[4:0]);
    check_eq("src_ready", obs_sr, e[9:5]);
    check_eq("proto_err", obs_err, e[14:10]);
`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("stall_cnt%0d", c), stall_cnt[c], e_stall[c]);
      check_eq($sformatf("xfer_cnt%0d", c), xfer_cnt[c], e_xfer[c]);
    end
`endif
    if (hist_on && cur_act3 && obs_dv[3] && !lat_seen) begin
      lat_hist[(cur_age3 > 15) ? 15 : cur_age3]++;
      beats3++;
      lat_seen = 1'b1;
    end
    last_sr = e[9:5];
    @(posedge clk);
    #1;
  endtask

  // A held beat stays valid until its expected handshake, so random traffic
  // is always protocol-legal.
  task automatic drive_rand(input int p_new, input int p_rdy);
    for (int c = 0; c < 5; c++) begin
      if (!(src_valid[c] && !last_sr[c])) begin
        src_valid[c] = new_beats && ($urandom_range(99) < p_new);
      end
      dst_ready[c] = ($urandom_range(99) < p_rdy);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    new_beats = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive_rand(0, 100);
      if (src_valid == 5'd0 && m_act == 5'd0) begin
        ok = 1'b1;
        break;
      end
      run_cycle();
    end
    check_eq("drain_done", 32'(ok), 32'd1);
    new_beats = 1'b1;
  endtask

  task automatic run_rand(input int n, input int p_new, input int p_rdy);
    for (int i = 0; i < n; i++) begin
      drive_rand(p_new, p_rdy);
      run_cycle();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] seq_dv;
    logic [3:0] seq_sr;
    bit         seen4;
    int         lat;
    int         cyc;

    rst_n     = 1'b0;
    cfg_mode  = 2'd0;
    cfg_dly   = 4'd0;
    cfg_ch_en = 5'h1F;
    src_valid = '0;
    dst_ready = '0;
    last_sr   = '0;
    lat_seen  = 1'b0;
    hist_on   = 1'b0;
    beats3    = 0;
    m_act     = '0;
    m_err     = '0;
    for (int c = 0; c < 5; c++) begin
      m_age[c] = 0;
      m_d[c]   = 0;
      m_lfsr[c] = SEED ^ 16'(c + 1);
    end
    for (int i = 0; i < 16; i++) lat_hist[i] = 0;

    #1;
    for (int i = 0; i < 3; i++) run_cycle();
    check_eq("reset_dv", obs_dv, 32'd0);
    check_eq("reset_err", obs_err, 32'd0);
    rst_n = 1'b1;

    // Bypass: AR passes straight through with zero latency.
    src_valid = 5'b01000;
    dst_ready = 5'b01000;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check_eq("byp_ar", 32'(obs_dv[3] & obs_sr[3]), 32'd1);
    end
    run_rand(200, 50, 50);
    drain();

    cfg_mode = 2'd3;
    run_rand(150, 50, 50);
    drain();

    // Fixed delay 3 on W: first dst_valid and handshake in cycle 3.
    cfg_mode  = 2'd1;
    cfg_dly   = 4'd3;
    src_valid = 5'b00010;
    dst_ready = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      run_cycle();
      seq_dv[k] = obs_dv[1];
      seq_sr[k] = obs_sr[1];
    end
    src_valid = '0;
    check_eq("d3_dst_valid_seq", 32'(seq_dv), 32'h8);
    check_eq("d3_src_ready_seq", 32'(seq_sr), 32'h8);
    drain();

    // R source drops valid during its delay.
    cfg_dly   = 4'd2;
    src_valid = 5'b10000;
    seen4     = 1'b0;
    run_cycle();
    seen4 |= obs_dv[4];
    src_valid = '0;
    for (int k = 1; k < 4; k++) begin
      run_cycle();
      seen4 |= obs_dv[4];
      if (k == 2) check_eq("drop_err", obs_err, 32'h10);
    end
    check_eq("drop_no_dv", 32'(seen4), 32'd0);

    // Reset in the middle of a 7-cycle delay.
    cfg_dly   = 4'd7;
    src_valid = 5'b00001;
    dst_ready = 5'b11111;
    for (int k = 0; k < 4; k++) run_cycle();
    rst_n = 1'b0;
    run_cycle();
    check_eq("rst_mid_dv", obs_dv, 32'd0);
    check_eq("rst_mid_err", obs_err, 32'd0);
    rst_n = 1'b1;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      run_cycle();
      if (obs_dv[0]) begin
        lat = k;
        break;
      end
    end
    check_eq("rst_new_lat", 32'(lat), 32'd7);
    src_valid = '0;
    drain();

    // Fixed delays on a random subset of channels.
    cfg_dly   = 4'd9;
    cfg_ch_en = 5'($urandom_range(31));
    run_rand(400, 60, 60);
    drain();

    // Zero fixed delay behaves like bypass.
    cfg_ch_en = 5'h1F;
    cfg_dly   = 4'd0;
    run_rand(300, 60, 50);
    drain();

`ifdef SCR1_TB_AXI_THROTTLE_STAT_EN
    src_valid = 5'b01000;
    dst_ready = 5'b01000;
    for (int i = 0; i < 280; i++) run_cycle();
    check_eq("xfer_sat", xfer_cnt[3], 32'(8'hFF));
    src_valid = '0;
    drain();
`endif

    // Random delays bounded by 5 on every channel; AR latencies collected.
    cfg_mode = 2'd2;
    cfg_dly  = 4'd5;
    hist_on  = 1'b1;
    beats3   = 0;
    cyc      = 0;
    while (beats3 < 1000 && cyc < 30000) begin
      drive_rand(70, 60);
      run_cycle();
      cyc++;
    end
    hist_on = 1'b0;
    check_eq("ar_beats_done", 32'(beats3 >= 1000), 32'd1);
    for (int v = 0; v < 16; v++) begin
      if (v <= 5) check_eq($sformatf("dly_seen_%0d", v), 32'(lat_hist[v] != 0), 32'd1);
      else        check_eq($sformatf("dly_over_%0d", v), 32'(lat_hist[v]), 32'd0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
